// File: rtl/game_timer_pkg.sv
// Shared types and helpers for the BCD game timer: FSM states, the packed
// mm:ss time word and load-value clamping.
package game_timer_pkg;

  typedef enum logic [1:0] {T_IDLE, T_RUN, T_PAUSE, T_EXPIRED} timer_state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  // Elaboration-time conversion of a decimal parameter into two BCD digits.
  function automatic logic [7:0] to_bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  // Saturate each field of a load value to its largest legal BCD value.
  function automatic bcd_time_t bcd_clamp(input logic [7:0] mins,
                                          input logic [7:0] secs,
                                          input logic [7:0] min_max);
    bcd_time_t t;
    t.mt = (mins[7:4] > 4'd9) ? 4'd9 : mins[7:4];
    t.mu = (mins[3:0] > 4'd9) ? 4'd9 : mins[3:0];
    t.st = (secs[7:4] > 4'd5) ? 4'd5 : secs[7:4];
    t.su = (secs[3:0] > 4'd9) ? 4'd9 : secs[3:0];
    if ({t.mt, t.mu} > min_max) begin
      t.mt = min_max[7:4];
      t.mu = min_max[3:0];
    end
    return t;
  endfunction

endpackage

// File: rtl/game_timer_bcd_digit.sv
// One BCD digit counting 0..MAX with up/down enables and a synchronous load;
// carry/borrow flag the wrap so digits can be chained.
module bcd_digit #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] value,
  output logic       carry,
  output logic       borrow
);

  assign carry  = inc && (value == MAX);
  assign borrow = dec && (value == 4'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= 4'd0;
    end else if (load) begin
      value <= load_val;
    end else if (inc) begin
      value <= carry ? 4'd0 : value + 4'd1;
    end else if (dec) begin
      value <= borrow ? MAX : value - 4'd1;
    end
  end

endmodule

// File: rtl/game_timer_bcd.sv
// mm:ss game timer counting up or down directly in BCD, with start/stop/clear/
// preload control, status pulses and a seven-segment-ready output word.
module game_timer_bcd
  import game_timer_pkg::*;
#(
  parameter int TICKS_PER_SEC = 25_200_000,
  parameter int MIN_MAX       = 99,
  parameter bit WRAP_EN       = 1'b1
) (
  input  logic        pixel_clk,
  input  logic        arst,
  input  logic        start_i,
  input  logic        stop_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [7:0]  load_min_i,
  input  logic [7:0]  load_sec_i,
  input  logic        mode_down_i,
  output logic        running_o,
  output logic        sec_tick_o,
  output logic        expired_o,
  output logic        wrap_o,
  output logic [15:0] time_bcd_o,
  output logic [31:0] sevseg_o
);

  localparam int              PW          = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_LAST  = PW'(TICKS_PER_SEC - 1);
  localparam logic [7:0]      MIN_MAX_BCD = to_bcd8(MIN_MAX);

  timer_state_t  state;
  logic          mode_down;
  logic [PW-1:0] presc;
  bcd_time_t     cur;
  bcd_time_t     load_value;
  logic [3:0]    mt_val, mu_val, st_val, su_val;
  logic          su_carry, su_borrow, st_carry, st_borrow, mu_carry, mu_borrow;
  logic          mt_carry_unused, mt_borrow_unused;
  logic          run_active, tick, tick_up, tick_down;
  logic          at_max, at_zero, at_one;
  logic          wrap_now, sat_now, down_end, load_all;

  assign cur = {mt_val, mu_val, st_val, su_val};

  // A stop, clear or load in the same cycle freezes the second in progress.
  assign run_active = (state == T_RUN) && !clear_i && !load_i && !stop_i;
  assign tick       = run_active && (presc == PRESC_LAST);

  assign at_max  = ({cur.mt, cur.mu} == MIN_MAX_BCD) && (cur.st == 4'd5) && (cur.su == 4'd9);
  assign at_zero = (cur == 16'h0000);
  assign at_one  = (cur == 16'h0001);

  assign tick_up   = tick && !mode_down;
  assign tick_down = tick && mode_down && !at_zero;
  assign wrap_now  = tick_up && at_max && WRAP_EN;
  assign sat_now   = tick_up && at_max && !WRAP_EN;
  assign down_end  = tick_down && at_one;

  assign load_all   = clear_i || load_i || wrap_now;
  assign load_value = (!clear_i && load_i) ? bcd_clamp(load_min_i, load_sec_i, MIN_MAX_BCD)
                                           : bcd_time_t'(16'h0000);

  // Minute rollover past MIN_MAX is handled by the wrap load, so the tens
  // digit's own carry/borrow never matters.
  bcd_digit #(.MAX(4'd9)) u_su (
    .clk(pixel_clk), .rst(arst), .inc(tick_up && !at_max), .dec(tick_down),
    .load(load_all), .load_val(load_value.su),
    .value(su_val), .carry(su_carry), .borrow(su_borrow)
  );

  bcd_digit #(.MAX(4'd5)) u_st (
    .clk(pixel_clk), .rst(arst), .inc(su_carry), .dec(su_borrow),
    .load(load_all), .load_val(load_value.st),
    .value(st_val), .carry(st_carry), .borrow(st_borrow)
  );

  bcd_digit #(.MAX(4'd9)) u_mu (
    .clk(pixel_clk), .rst(arst), .inc(st_carry), .dec(st_borrow),
    .load(load_all), .load_val(load_value.mu),
    .value(mu_val), .carry(mu_carry), .borrow(mu_borrow)
  );

  bcd_digit #(.MAX(4'd9)) u_mt (
    .clk(pixel_clk), .rst(arst), .inc(mu_carry), .dec(mu_borrow),
    .load(load_all), .load_val(load_value.mt),
    .value(mt_val), .carry(mt_carry_unused), .borrow(mt_borrow_unused)
  );

  always_ff @(posedge pixel_clk or posedge arst) begin
    if (arst) begin
      state      <= T_IDLE;
      mode_down  <= 1'b0;
      presc      <= '0;
      running_o  <= 1'b0;
      sec_tick_o <= 1'b0;
      expired_o  <= 1'b0;
      wrap_o     <= 1'b0;
    end else begin
      sec_tick_o <= (tick_up && !sat_now) || tick_down;
      wrap_o     <= wrap_now;
      expired_o  <= 1'b0;
      if (run_active) begin
        presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
      end
      if (clear_i || load_i) begin
        state     <= T_IDLE;
        running_o <= 1'b0;
        presc     <= '0;
      end else begin
        case (state)
          T_IDLE: if (start_i && !stop_i) begin
            state     <= T_RUN;
            running_o <= 1'b1;
            mode_down <= mode_down_i;
            presc     <= '0;
          end
          T_RUN: if (stop_i) begin
            state     <= T_PAUSE;
            running_o <= 1'b0;
          end else if (sat_now || down_end || (mode_down && at_zero)) begin
            state     <= T_EXPIRED;
            running_o <= 1'b0;
            expired_o <= 1'b1;
          end
          T_PAUSE: if (start_i && !stop_i) begin
            state     <= T_RUN;
            running_o <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign time_bcd_o = cur;
  assign sevseg_o   = {16'h0000, cur};

endmodule

// File: tb/tb_game_timer_bcd.sv
// Scoreboard bench for game_timer_bcd: three instances (99-minute wrapping,
// 1-minute wrapping, 1-minute saturating) share one stimulus stream.
module tb_game_timer_bcd;

  localparam int SEL_TIME  = 0, SEL_RUN  = 1, SEL_TICK = 2, SEL_EXP = 3, SEL_WRAP = 4;
  localparam int SEL_SEG   = 5, SEL_WTIME = 6, SEL_WWRAP = 7, SEL_WTICK = 8, SEL_WRUN = 9;
  localparam int SEL_STIME = 10, SEL_SEXP = 11, SEL_SRUN = 12, SEL_STICK = 13;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] value;
  } exp_t;

  logic        pixel_clk = 1'b0;
  logic        arst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0, mode_down = 1'b0;
  logic [7:0]  load_min = 8'h00, load_sec = 8'h00;

  logic        running, sec_tick, expired, wrap;
  logic [15:0] time_bcd;
  logic [31:0] sevseg;
  logic        w_running, w_sec_tick, w_expired, w_wrap;
  logic [15:0] w_time_bcd;
  logic [31:0] w_sevseg;
  logic        s_running, s_sec_tick, s_expired, s_wrap;
  logic [15:0] s_time_bcd;
  logic [31:0] s_sevseg;

  exp_t sb[$];
  int   testsRun = 0;
  int   testsFailed = 0;

  always #5 pixel_clk = ~pixel_clk;

  game_timer_bcd #(.TICKS_PER_SEC(4), .MIN_MAX(99), .WRAP_EN(1'b1)) dut (
    .pixel_clk(pixel_clk), .arst(arst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .load_i(load), .load_min_i(load_min), .load_sec_i(load_sec), .mode_down_i(mode_down),
    .running_o(running), .sec_tick_o(sec_tick), .expired_o(expired), .wrap_o(wrap),
    .time_bcd_o(time_bcd), .sevseg_o(sevseg)
  );

  game_timer_bcd #(.TICKS_PER_SEC(4), .MIN_MAX(1), .WRAP_EN(1'b1)) dut_w (
    .pixel_clk(pixel_clk), .arst(arst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .load_i(load), .load_min_i(load_min), .load_sec_i(load_sec), .mode_down_i(mode_down),
    .running_o(w_running), .sec_tick_o(w_sec_tick), .expired_o(w_expired), .wrap_o(w_wrap),
    .time_bcd_o(w_time_bcd), .sevseg_o(w_sevseg)
  );

  game_timer_bcd #(.TICKS_PER_SEC(4), .MIN_MAX(1), .WRAP_EN(1'b0)) dut_s (
    .pixel_clk(pixel_clk), .arst(arst), .start_i(start), .stop_i(stop), .clear_i(clear),
    .load_i(load), .load_min_i(load_min), .load_sec_i(load_sec), .mode_down_i(mode_down),
    .running_o(s_running), .sec_tick_o(s_sec_tick), .expired_o(s_expired), .wrap_o(s_wrap),
    .time_bcd_o(s_time_bcd), .sevseg_o(s_sevseg)
  );

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      SEL_TIME:  return {16'h0, time_bcd};
      SEL_RUN:   return {31'h0, running};
      SEL_TICK:  return {31'h0, sec_tick};
      SEL_EXP:   return {31'h0, expired};
      SEL_WRAP:  return {31'h0, wrap};
      SEL_SEG:   return sevseg;
      SEL_WTIME: return {16'h0, w_time_bcd};
      SEL_WWRAP: return {31'h0, w_wrap};
      SEL_WTICK: return {31'h0, w_sec_tick};
      SEL_WRUN:  return {31'h0, w_running};
      SEL_STIME: return {16'h0, s_time_bcd};
      SEL_SEXP:  return {31'h0, s_expired};
      SEL_SRUN:  return {31'h0, s_running};
      SEL_STICK: return {31'h0, s_sec_tick};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushExp(input string tag, input int sel, input logic [31:0] value);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.value = value;
    sb.push_back(e);
  endtask

  task automatic drainCheck();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput(e.tag, observe(e.sel), e.value);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge pixel_clk);
      #1;
    end
  endtask

  // Drive one cycle of control inputs; pulses drop after the edge, data stays.
  task automatic applyStimulus(input logic st, input logic sp, input logic cl, input logic ld,
                               input logic [7:0] lm, input logic [7:0] ls, input logic md);
    start = st; stop = sp; clear = cl; load = ld;
    load_min = lm; load_sec = ls; mode_down = md;
    step(1);
    start = 1'b0; stop = 1'b0; clear = 1'b0; load = 1'b0;
  endtask

  initial begin
    int ticks, offbeat, exp_count;

    step(2);
    pushExp("reset_time", SEL_TIME, 32'h0000);
    pushExp("reset_run", SEL_RUN, 32'h0);
    pushExp("reset_tick", SEL_TICK, 32'h0);
    pushExp("reset_seg", SEL_SEG, 32'h0000_0000);
    drainCheck();
    arst = 1'b0;

    // Asynchronous reset in the middle of a running 00:37
    pushExp("load_0037", SEL_TIME, 32'h0037);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h37, 1'b0);
    drainCheck();
    pushExp("run_0037", SEL_RUN, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h37, 1'b0);
    drainCheck();
    step(2);
    #2 arst = 1'b1;
    #1;
    pushExp("arst_time", SEL_TIME, 32'h0000);
    pushExp("arst_run", SEL_RUN, 32'h0);
    pushExp("arst_tick", SEL_TICK, 32'h0);
    pushExp("arst_exp", SEL_EXP, 32'h0);
    drainCheck();
    step(1);
    arst = 1'b0;
    step(5);
    pushExp("post_reset_idle_time", SEL_TIME, 32'h0000);
    pushExp("post_reset_idle_run", SEL_RUN, 32'h0);
    drainCheck();

    // Count up for one minute
    pushExp("up_start_run", SEL_RUN, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drainCheck();
    ticks = 0;
    offbeat = 0;
    for (int i = 1; i <= 240; i++) begin
      if (i == 4) pushExp("up_first_tick", SEL_TIME, 32'h0001);
      if (i == 40) pushExp("up_sec_carry", SEL_TIME, 32'h0010);
      if (i == 240) begin
        pushExp("up_min_carry", SEL_TIME, 32'h0100);
        pushExp("up_sevseg", SEL_SEG, 32'h0000_0100);
      end
      step(1);
      if (sec_tick) begin
        ticks++;
        if (i % 4 != 0) offbeat++;
      end
      drainCheck();
    end
    checkOutput("up_tick_count", 32'(ticks), 32'd60);
    checkOutput("up_tick_spacing", 32'(offbeat), 32'd0);
    pushExp("stop_run", SEL_RUN, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drainCheck();
    step(8);
    pushExp("pause_hold", SEL_TIME, 32'h0100);
    drainCheck();

    // Countdown from 00:02 to expiry
    pushExp("load_0002", SEL_TIME, 32'h0002);
    pushExp("load_idle", SEL_RUN, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h02, 1'b0);
    drainCheck();
    pushExp("down_start_run", SEL_RUN, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1);
    drainCheck();
    exp_count = 0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) begin
        pushExp("down_0001", SEL_TIME, 32'h0001);
        pushExp("down_0001_tick", SEL_TICK, 32'h1);
        pushExp("down_0001_noexp", SEL_EXP, 32'h0);
      end
      if (i == 8) begin
        pushExp("down_0000", SEL_TIME, 32'h0000);
        pushExp("down_0000_tick", SEL_TICK, 32'h1);
        pushExp("down_expired", SEL_EXP, 32'h1);
        pushExp("down_not_run", SEL_RUN, 32'h0);
      end
      step(1);
      if (expired) exp_count++;
      drainCheck();
    end
    checkOutput("down_expired_count", 32'(exp_count), 32'd1);
    pushExp("expired_ignores_start", SEL_RUN, 32'h0);
    pushExp("expired_holds_time", SEL_TIME, 32'h0000);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 1'b1);
    drainCheck();

    // Countdown started at 00:00 expires on the following cycle
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    pushExp("zero_start_run", SEL_RUN, 32'h1);
    pushExp("zero_start_noexp", SEL_EXP, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    drainCheck();
    step(1);
    pushExp("zero_start_expired", SEL_EXP, 32'h1);
    pushExp("zero_start_stopped", SEL_RUN, 32'h0);
    pushExp("zero_start_notick", SEL_TICK, 32'h0);
    drainCheck();
    step(1);
    pushExp("zero_start_pulse_end", SEL_EXP, 32'h0);
    drainCheck();

    // Pause two cycles into a second, start+stop while paused, then resume
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(2);
    pushExp("pause_run", SEL_RUN, 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drainCheck();
    pushExp("start_stop_stays_paused", SEL_RUN, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drainCheck();
    step(3);
    pushExp("paused_no_tick", SEL_TIME, 32'h0000);
    drainCheck();
    pushExp("resume_run", SEL_RUN, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    drainCheck();
    step(1);
    pushExp("resume_early", SEL_TIME, 32'h0000);
    pushExp("resume_early_tick", SEL_TICK, 32'h0);
    drainCheck();
    step(1);
    pushExp("resume_tick_time", SEL_TIME, 32'h0001);
    pushExp("resume_tick", SEL_TICK, 32'h1);
    drainCheck();

    // Invalid BCD load clamps; clear beats load in the same cycle
    pushExp("clamp_time", SEL_TIME, 32'h9959);
    pushExp("clamp_seg", SEL_SEG, 32'h0000_9959);
    pushExp("clamp_idle", SEL_RUN, 32'h0);
    pushExp("clamp_min_max1", SEL_WTIME, 32'h0159);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'hFA, 8'h7C, 1'b0);
    drainCheck();
    pushExp("clear_over_load", SEL_TIME, 32'h0000);
    pushExp("clear_over_load_w", SEL_WTIME, 32'h0000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0);
    drainCheck();

    // MIN_MAX=1: wrapping vs saturating instance at 01:59
    pushExp("w_load", SEL_WTIME, 32'h0159);
    pushExp("s_load", SEL_STIME, 32'h0159);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 8'h59, 1'b0);
    drainCheck();
    pushExp("w_run", SEL_WRUN, 32'h1);
    pushExp("s_run", SEL_SRUN, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h59, 1'b0);
    drainCheck();
    step(3);
    pushExp("w_before_wrap", SEL_WTIME, 32'h0159);
    pushExp("w_no_early_wrap", SEL_WWRAP, 32'h0);
    drainCheck();
    step(1);
    pushExp("w_wrapped", SEL_WTIME, 32'h0000);
    pushExp("w_wrap_pulse", SEL_WWRAP, 32'h1);
    pushExp("w_wrap_tick", SEL_WTICK, 32'h1);
    pushExp("w_still_run", SEL_WRUN, 32'h1);
    pushExp("s_hold", SEL_STIME, 32'h0159);
    pushExp("s_expired", SEL_SEXP, 32'h1);
    pushExp("s_stopped", SEL_SRUN, 32'h0);
    pushExp("s_no_tick", SEL_STICK, 32'h0);
    drainCheck();
    step(1);
    pushExp("w_wrap_pulse_end", SEL_WWRAP, 32'h0);
    pushExp("s_exp_pulse_end", SEL_SEXP, 32'h0);
    drainCheck();
    step(3);
    pushExp("w_after_wrap", SEL_WTIME, 32'h0001);
    drainCheck();
    pushExp("s_ignores_start", SEL_SRUN, 32'h0);
    pushExp("s_still_holds", SEL_STIME, 32'h0159);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h59, 1'b0);
    drainCheck();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
